// File: rtl/eth_rx_mac_filter.sv
// Receive-side destination-address filter behind the MII MAC rx stream.
// Delays each frame by six bytes, forwards or drops it on the DA, and counts both outcomes.
module eth_rx_mac_filter #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 rx_clk,
   input  logic                 rx_rst,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   input  logic                 s_axis_tuser,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   output logic                 m_axis_tlast,
   output logic                 m_axis_tuser,
   input  logic [47:0]          local_mac,
   input  logic                 promisc_en,
   input  logic                 broadcast_en,
   input  logic                 multicast_en,
   output logic [CNT_WIDTH-1:0] accept_count,
   output logic [CNT_WIDTH-1:0] drop_count,
   output logic                 overrun
);

   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned DA_BYTES = 6;
   localparam int unsigned DL_W     = BYTE_W * DA_BYTES;
   localparam int unsigned IDX_W    = 3;
   localparam int unsigned MC_BIT   = DL_W - BYTE_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DA_BYTES - 1);

   typedef enum logic [1:0] {
      HDR,
      FORWARD,
      DRAIN,
      DROP
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DL_W-1:0]      dl_q, dl_d;
   logic                 tuser_lat_q, tuser_lat_d;
   logic                 discard_q, discard_d;

   logic [BYTE_W-1:0]    tdata_d;
   logic                 tvalid_d, tlast_d, tuser_d, overrun_d;
   logic [CNT_WIDTH-1:0] acc_d, drop_d;

   logic [DL_W-1:0]      dl_shift;
   logic                 accept;
   logic [BYTE_W-1:0]    drain_byte;
   logic                 inc_acc, inc_drop;

   // Newest byte enters at the bottom, so after six beats the DA lines up with local_mac.
   assign dl_shift = {dl_q[DL_W-BYTE_W-1:0], s_axis_tdata};

   assign accept = promisc_en
                 | (dl_shift == local_mac)
                 | (broadcast_en & (&dl_shift))
                 | (multicast_en & dl_shift[MC_BIT]);

   // DRAIN walks the frozen delay line from oldest to newest.
   always_comb begin
      drain_byte = '0;
      case (idx_q)
         3'd0:    drain_byte = dl_q[47:40];
         3'd1:    drain_byte = dl_q[39:32];
         3'd2:    drain_byte = dl_q[31:24];
         3'd3:    drain_byte = dl_q[23:16];
         3'd4:    drain_byte = dl_q[15:8];
         3'd5:    drain_byte = dl_q[7:0];
         default: drain_byte = '0;
      endcase
   end

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         state_q       <= HDR;
         cnt_q         <= '0;
         idx_q         <= '0;
         dl_q          <= '0;
         tuser_lat_q   <= 1'b0;
         discard_q     <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         accept_count  <= '0;
         drop_count    <= '0;
         overrun       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         dl_q          <= dl_d;
         tuser_lat_q   <= tuser_lat_d;
         discard_q     <= discard_d;
         m_axis_tdata  <= tdata_d;
         m_axis_tvalid <= tvalid_d;
         m_axis_tlast  <= tlast_d;
         m_axis_tuser  <= tuser_d;
         accept_count  <= acc_d;
         drop_count    <= drop_d;
         overrun       <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      dl_d        = dl_q;
      tuser_lat_d = tuser_lat_q;
      discard_d   = discard_q;
      tdata_d     = '0;
      tvalid_d    = 1'b0;
      tlast_d     = 1'b0;
      tuser_d     = 1'b0;
      overrun_d   = overrun;
      inc_acc     = 1'b0;
      inc_drop    = 1'b0;

      case (state_q)
         HDR: begin
            if (s_axis_tvalid) begin
               dl_d = dl_shift;
               if (cnt_q == LAST_IDX) begin
                  cnt_d = '0;
                  if (accept) begin
                     if (s_axis_tlast) begin
                        tuser_lat_d = s_axis_tuser;
                        idx_d       = '0;
                        state_d     = DRAIN;
                     end else begin
                        state_d = FORWARD;
                     end
                  end else begin
                     inc_drop = 1'b1;
                     state_d  = s_axis_tlast ? HDR : DROP;
                  end
               end else if (s_axis_tlast) begin
                  // Runt: ended before the DA was complete.
                  inc_drop = 1'b1;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + IDX_W'(1);
               end
            end
         end

         FORWARD: begin
            if (s_axis_tvalid) begin
               dl_d     = dl_shift;
               tdata_d  = dl_q[DL_W-1:DL_W-BYTE_W];
               tvalid_d = 1'b1;
               if (s_axis_tlast) begin
                  tuser_lat_d = s_axis_tuser;
                  idx_d       = '0;
                  state_d     = DRAIN;
               end
            end
         end

         DRAIN: begin
            tdata_d  = drain_byte;
            tvalid_d = 1'b1;
            // A beat here belongs to a frame that started too early; count it once and discard it.
            if (s_axis_tvalid) begin
               overrun_d = 1'b1;
               if (!discard_q) begin
                  inc_drop = 1'b1;
               end
               discard_d = !s_axis_tlast;
            end
            if (idx_q == LAST_IDX) begin
               tlast_d   = 1'b1;
               tuser_d   = tuser_lat_q;
               inc_acc   = 1'b1;
               cnt_d     = '0;
               idx_d     = '0;
               state_d   = discard_d ? DROP : HDR;
               discard_d = 1'b0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         DROP: begin
            if (s_axis_tvalid && s_axis_tlast) begin
               cnt_d   = '0;
               state_d = HDR;
            end
         end

         default: begin
            state_d = HDR;
         end
      endcase

      acc_d = accept_count;
      if (inc_acc && (accept_count != {CNT_WIDTH{1'b1}})) begin
         acc_d = accept_count + CNT_WIDTH'(1);
      end
      drop_d = drop_count;
      if (inc_drop && (drop_count != {CNT_WIDTH{1'b1}})) begin
         drop_d = drop_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Directed bench for eth_rx_mac_filter: DA filtering, latency, runts, tuser, overrun, saturation, reset.
module tb_eth_rx_mac_filter;

   localparam int unsigned CW   = 4;
   localparam int          CMAX = 15;
   localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;

   logic          rx_clk = 1'b0;
   logic          rx_rst = 1'b1;
   logic [7:0]    s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tlast = 1'b0;
   logic          s_axis_tuser = 1'b0;
   logic [7:0]    m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tuser;
   logic [47:0]   local_mac = LMAC;
   logic          promisc_en = 1'b0;
   logic          broadcast_en = 1'b0;
   logic          multicast_en = 1'b0;
   logic [CW-1:0] accept_count;
   logic [CW-1:0] drop_count;
   logic          overrun;

   eth_rx_mac_filter #(.CNT_WIDTH(CW)) dut (
      .rx_clk        (rx_clk),
      .rx_rst        (rx_rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .local_mac     (local_mac),
      .promisc_en    (promisc_en),
      .broadcast_en  (broadcast_en),
      .multicast_en  (multicast_en),
      .accept_count  (accept_count),
      .drop_count    (drop_count),
      .overrun       (overrun)
   );

   always #5 rx_clk = ~rx_clk;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic       u;
      int         c;
   } beat_t;

   beat_t      outq[$];
   logic [7:0] frm[$];
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   int         exp_acc = 0;
   int         exp_drop = 0;

   // Cycle index advances at each rising edge; outputs are captured 1 ns later.
   always @(posedge rx_clk) begin
      beat_t b;
      cyc = cyc + 1;
      #1;
      if (m_axis_tvalid === 1'b1) begin
         b.d = m_axis_tdata;
         b.l = m_axis_tlast;
         b.u = m_axis_tuser;
         b.c = cyc;
         outq.push_back(b);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic int sat_inc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic make_frame(input logic [47:0] da, input int len, input logic [7:0] seed);
      frm.delete();
      for (int i = 0; i < len; i++) begin
         if (i < 6) frm.push_back(da[8*(5-i) +: 8]);
         else       frm.push_back(seed + 8'(i));
      end
   endtask

   // Drives frm; gap = cycles per beat; noise goes on tuser of non-last beats.
   task automatic send(input int gap, input logic tu, input logic noise, output int tl_cyc);
      tl_cyc = 0;
      for (int i = 0; i < frm.size(); i++) begin
         @(negedge rx_clk);
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = frm[i];
         s_axis_tlast  = (i == frm.size() - 1);
         s_axis_tuser  = (i == frm.size() - 1) ? tu : noise;
         if (i == frm.size() - 1) tl_cyc = cyc;
         for (int g = 1; g < gap; g++) begin
            @(negedge rx_clk);
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tuser  = 1'b0;
         end
      end
      if (gap == 1) begin
         @(negedge rx_clk);
         s_axis_tvalid = 1'b0;
         s_axis_tlast  = 1'b0;
         s_axis_tuser  = 1'b0;
      end
   endtask

   // Beat-level differences between the captured output and frm.
   function automatic int frame_errs(input logic exp_u);
      int e = 0;
      int n = frm.size();
      if (outq.size() != n) return 1000 + outq.size();
      for (int i = 0; i < n; i++) begin
         if (outq[i].d !== frm[i]) e++;
         if (outq[i].l !== (i == n - 1)) e++;
         if (outq[i].u !== ((i == n - 1) ? exp_u : 1'b0)) e++;
      end
      return e;
   endfunction

   function automatic int last_lat(input int tl);
      return (outq.size() > 0) ? outq[outq.size()-1].c - tl : -1;
   endfunction

   task automatic test_reset();
      #12;
      vectors++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 || m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_axis: got v=%b d=%h l=%b u=%b, want all 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser);
      end
      vectors++;
      if (accept_count !== 4'd0 || drop_count !== 4'd0 || overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_status: got acc=%0d drop=%0d ovr=%b, want 0 0 0", accept_count, drop_count, overrun);
      end
      @(negedge rx_clk);
      rx_rst = 1'b0;
      repeat (2) @(negedge rx_clk);
   endtask

   task automatic test_unicast();
      int tl, e, lat;
      outq.delete();
      make_frame(LMAC, 64, 8'h10);
      send(2, 1'b0, 1'b0, tl);
      repeat (12) @(negedge rx_clk);
      exp_acc = sat_inc(exp_acc);
      e = frame_errs(1'b0);
      vectors++;
      if (e !== 0) begin
         miscompares++;
         $display("FAIL unicast_frame: %0d beat errors, got %0d beats, want 64", e, outq.size());
      end
      lat = last_lat(tl);
      vectors++;
      if (lat !== 7) begin
         miscompares++;
         $display("FAIL unicast_tlast_latency: got %0d cycles, want 7", lat);
      end
      vectors++;
      if (outq.size() == 64 && outq[57].c - tl !== 1) begin
         miscompares++;
         $display("FAIL unicast_byte58_latency: got %0d cycles, want 1", outq[57].c - tl);
      end
      vectors++;
      if (accept_count !== CW'(exp_acc) || drop_count !== CW'(exp_drop)) begin
         miscompares++;
         $display("FAIL unicast_counts: got acc=%0d drop=%0d, want %0d %0d", accept_count, drop_count, exp_acc, exp_drop);
      end
   endtask

   task automatic test_promisc();
      int tl, e;
      outq.delete();
      make_frame(48'h02_00_00_00_00_02, 64, 8'h20);
      send(2, 1'b0, 1'b0, tl);
      repeat (12) @(negedge rx_clk);
      exp_drop = sat_inc(exp_drop);
      vectors++;
      if (outq.size() !== 0) begin
         miscompares++;
         $display("FAIL foreign_da_dropped: got %0d output beats, want 0", outq.size());
      end
      vectors++;
      if (drop_count !== CW'(exp_drop) || accept_count !== CW'(exp_acc)) begin
         miscompares++;
         $display("FAIL foreign_da_counts: got acc=%0d drop=%0d, want %0d %0d", accept_count, drop_count, exp_acc, exp_drop);
      end
      promisc_en = 1'b1;
      send(2, 1'b0, 1'b0, tl);
      repeat (12) @(negedge rx_clk);
      promisc_en = 1'b0;
      exp_acc = sat_inc(exp_acc);
      e = frame_errs(1'b0);
      vectors++;
      if (e !== 0) begin
         miscompares++;
         $display("FAIL promisc_frame: %0d beat errors, got %0d beats, want 64", e, outq.size());
      end
      vectors++;
      if (accept_count !== CW'(exp_acc)) begin
         miscompares++;
         $display("FAIL promisc_accept_count: got %0d, want %0d", accept_count, exp_acc);
      end
   endtask

   task automatic test_broadcast_multicast();
      int tl, e;
      outq.delete();
      broadcast_en = 1'b1;
      make_frame(48'hFF_FF_FF_FF_FF_FF, 20, 8'h30);
      send(1, 1'b0, 1'b0, tl);
      repeat (10) @(negedge rx_clk);
      exp_acc = sat_inc(exp_acc);
      e = frame_errs(1'b0);
      vectors++;
      if (e !== 0) begin
         miscompares++;
         $display("FAIL broadcast_on: %0d beat errors, got %0d beats, want 20", e, outq.size());
      end
      outq.delete();
      broadcast_en = 1'b0;
      send(1, 1'b0, 1'b0, tl);
      repeat (10) @(negedge rx_clk);
      exp_drop = sat_inc(exp_drop);
      vectors++;
      if (outq.size() !== 0 || drop_count !== CW'(exp_drop)) begin
         miscompares++;
         $display("FAIL broadcast_off: got %0d beats drop=%0d, want 0 beats drop=%0d", outq.size(), drop_count, exp_drop);
      end
      outq.delete();
      multicast_en = 1'b1;
      make_frame(48'h01_00_5E_00_00_01, 24, 8'h40);
      send(1, 1'b0, 1'b0, tl);
      repeat (10) @(negedge rx_clk);
      multicast_en = 1'b0;
      exp_acc = sat_inc(exp_acc);
      e = frame_errs(1'b0);
      vectors++;
      if (e !== 0 || accept_count !== CW'(exp_acc)) begin
         miscompares++;
         $display("FAIL multicast_on: %0d beat errors acc=%0d, want 0 errors acc=%0d", e, accept_count, exp_acc);
      end
   endtask

   task automatic test_runt();
      int tl, e, lat;
      outq.delete();
      make_frame(LMAC, 4, 8'h50);
      send(1, 1'b0, 1'b0, tl);
      repeat (6) @(negedge rx_clk);
      exp_drop = sat_inc(exp_drop);
      vectors++;
      if (outq.size() !== 0 || drop_count !== CW'(exp_drop)) begin
         miscompares++;
         $display("FAIL runt4: got %0d beats drop=%0d, want 0 beats drop=%0d", outq.size(), drop_count, exp_drop);
      end
      make_frame(LMAC, 30, 8'h60);
      send(1, 1'b0, 1'b0, tl);
      repeat (10) @(negedge rx_clk);
      exp_acc = sat_inc(exp_acc);
      e = frame_errs(1'b0);
      vectors++;
      if (e !== 0) begin
         miscompares++;
         $display("FAIL after_runt_frame: %0d beat errors, got %0d beats, want 30", e, outq.size());
      end
      outq.delete();
      make_frame(LMAC, 5, 8'h70);
      send(1, 1'b0, 1'b0, tl);
      repeat (8) @(negedge rx_clk);
      exp_drop = sat_inc(exp_drop);
      vectors++;
      if (outq.size() !== 0 || drop_count !== CW'(exp_drop)) begin
         miscompares++;
         $display("FAIL runt5: got %0d beats drop=%0d, want 0 beats drop=%0d", outq.size(), drop_count, exp_drop);
      end
      // Exactly-six-byte frame: decision and tlast on the same beat.
      make_frame(LMAC, 6, 8'h80);
      send(1, 1'b1, 1'b0, tl);
      repeat (10) @(negedge rx_clk);
      exp_acc = sat_inc(exp_acc);
      e = frame_errs(1'b1);
      lat = last_lat(tl);
      vectors++;
      if (e !== 0 || lat !== 7) begin
         miscompares++;
         $display("FAIL six_byte_frame: %0d beat errors latency=%0d, want 0 errors latency=7", e, lat);
      end
      vectors++;
      if (accept_count !== CW'(exp_acc) || drop_count !== CW'(exp_drop)) begin
         miscompares++;
         $display("FAIL runt_counts: got acc=%0d drop=%0d, want %0d %0d", accept_count, drop_count, exp_acc, exp_drop);
      end
   endtask

   task automatic test_tuser();
      int tl, e;
      outq.delete();
      make_frame(LMAC, 16, 8'h90);
      send(1, 1'b1, 1'b0, tl);
      repeat (10) @(negedge rx_clk);
      exp_acc = sat_inc(exp_acc);
      e = frame_errs(1'b1);
      vectors++;
      if (e !== 0) begin
         miscompares++;
         $display("FAIL tuser_set: %0d beat errors, got %0d beats, want 16", e, outq.size());
      end
      outq.delete();
      make_frame(LMAC, 16, 8'hA0);
      send(1, 1'b0, 1'b1, tl);
      repeat (10) @(negedge rx_clk);
      exp_acc = sat_inc(exp_acc);
      e = frame_errs(1'b0);
      vectors++;
      if (e !== 0) begin
         miscompares++;
         $display("FAIL tuser_clear: %0d beat errors, got %0d beats, want 16", e, outq.size());
      end
   endtask

   task automatic test_back_to_back();
      int tl, e;
      logic [7:0] fa[$];
      outq.delete();
      make_frame(LMAC, 20, 8'hB0);
      fa = frm;
      send(1, 1'b0, 1'b0, tl);
      make_frame(LMAC, 20, 8'hC0);
      send(1, 1'b0, 1'b0, tl);
      repeat (10) @(negedge rx_clk);
      exp_acc  = sat_inc(exp_acc);
      exp_drop = sat_inc(exp_drop);
      frm = fa;
      e = frame_errs(1'b0);
      vectors++;
      if (e !== 0) begin
         miscompares++;
         $display("FAIL overrun_first_frame: %0d beat errors, got %0d beats, want 20", e, outq.size());
      end
      vectors++;
      if (overrun !== 1'b1) begin
         miscompares++;
         $display("FAIL overrun_flag: got %b, want 1", overrun);
      end
      vectors++;
      if (accept_count !== CW'(exp_acc) || drop_count !== CW'(exp_drop)) begin
         miscompares++;
         $display("FAIL overrun_counts: got acc=%0d drop=%0d, want %0d %0d", accept_count, drop_count, exp_acc, exp_drop);
      end
      outq.delete();
      make_frame(LMAC, 12, 8'hD0);
      send(1, 1'b0, 1'b0, tl);
      repeat (10) @(negedge rx_clk);
      exp_acc = sat_inc(exp_acc);
      e = frame_errs(1'b0);
      vectors++;
      if (e !== 0 || overrun !== 1'b1) begin
         miscompares++;
         $display("FAIL after_overrun_frame: %0d beat errors ovr=%b, want 0 errors ovr=1", e, overrun);
      end
   endtask

   task automatic test_saturation();
      int tl;
      for (int k = 0; k < 6; k++) begin
         make_frame(LMAC, 6, 8'(k));
         send(1, 1'b0, 1'b0, tl);
         repeat (10) @(negedge rx_clk);
         exp_acc = sat_inc(exp_acc);
      end
      for (int k = 0; k < 12; k++) begin
         make_frame(LMAC, 1, 8'h00);
         send(1, 1'b0, 1'b0, tl);
         @(negedge rx_clk);
         exp_drop = sat_inc(exp_drop);
      end
      repeat (4) @(negedge rx_clk);
      vectors++;
      if (accept_count !== 4'd15 || exp_acc != CMAX) begin
         miscompares++;
         $display("FAIL accept_saturate: got %0d, want 15", accept_count);
      end
      vectors++;
      if (drop_count !== 4'd15 || exp_drop != CMAX) begin
         miscompares++;
         $display("FAIL drop_saturate: got %0d, want 15", drop_count);
      end
   endtask

   task automatic test_reset_mid();
      int tl, e;
      outq.delete();
      make_frame(LMAC, 40, 8'hE0);
      for (int i = 0; i < 10; i++) begin
         @(negedge rx_clk);
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = frm[i];
         s_axis_tlast  = 1'b0;
         s_axis_tuser  = 1'b0;
      end
      #2;
      vectors++;
      if (m_axis_tvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_forwarding: got tvalid=%b, want 1", m_axis_tvalid);
      end
      rx_rst = 1'b1;
      #1;
      vectors++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 || accept_count !== 4'd0 || drop_count !== 4'd0 || overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: got v=%b d=%h acc=%0d drop=%0d ovr=%b, want all 0",
                  m_axis_tvalid, m_axis_tdata, accept_count, drop_count, overrun);
      end
      @(negedge rx_clk);
      s_axis_tvalid = 1'b0;
      rx_rst = 1'b0;
      exp_acc  = 0;
      exp_drop = 0;
      repeat (3) @(negedge rx_clk);
      outq.delete();
      make_frame(LMAC, 20, 8'hF0);
      send(1, 1'b0, 1'b0, tl);
      repeat (10) @(negedge rx_clk);
      exp_acc = sat_inc(exp_acc);
      e = frame_errs(1'b0);
      vectors++;
      if (e !== 0 || accept_count !== CW'(exp_acc) || drop_count !== CW'(exp_drop)) begin
         miscompares++;
         $display("FAIL post_reset_frame: %0d beat errors acc=%0d drop=%0d, want 0 errors acc=%0d drop=%0d",
                  e, accept_count, drop_count, exp_acc, exp_drop);
      end
   endtask

   initial begin
      test_reset();
      test_unicast();
      test_promisc();
      test_broadcast_multicast();
      test_runt();
      test_tuser();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
